// File: rtl/ibex_fp_pkg.sv
// ibex_fp_pkg
// Shared definitions for the Ibex FP register file and its scoreboard:
// default geometry and the encoding of the protocol-error cause.
package ibex_fp_pkg;

    localparam int unsigned FpRfNumWords  = 32;
    localparam int unsigned FpRfAddrWidth = $clog2(FpRfNumWords);

    // Cause of an err_o pulse. A dual write to one address is reported in
    // preference to a write to a non-pending register.
    typedef enum logic [1:0] {
        ErrNone       = 2'd0,
        ErrDualWrite  = 2'd1,
        ErrNotPending = 2'd2
    } fp_rf_err_e;

endpackage

// File: rtl/ibex_fp_scoreboard.sv
// ibex_fp_scoreboard
// Per-register pending bits for the FP register file. A destination is
// reserved at issue and released by the FPU (port A) or LSU (port B)
// writeback. Also produces the pending-register count and a one-cycle
// protocol-error pulse.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   raddr_i              flattened read addresses, NumReadPorts x AddrWidth
//   rbusy_o              per read port: addressed register is pending
//   issue_valid_i/addr_i reservation request and destination
//   issue_ready_o        reservation can be accepted this cycle
//   we_a_i/waddr_a_i     FPU writeback enable/address
//   we_b_i/waddr_b_i     LSU writeback enable/address
//   flush_i              drop every reservation
//   pending_cnt_o        registered count of pending registers
//   err_o                registered one-cycle protocol-error pulse
//
// Build option: IBEX_FP_RF_BYPASS_EN makes a clearing write visible on
// rbusy_o and issue_ready_o in the same cycle as the write.
module ibex_fp_scoreboard
    import ibex_fp_pkg::*;
#(
    parameter int unsigned NumWords     = FpRfNumWords,
    parameter int unsigned NumReadPorts = 3,
    parameter int unsigned AddrWidth    = $clog2(NumWords)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReadPorts*AddrWidth-1:0] raddr_i,
    output logic [NumReadPorts-1:0]           rbusy_o,
    input  logic                              issue_valid_i,
    input  logic [AddrWidth-1:0]              issue_addr_i,
    output logic                              issue_ready_o,
    input  logic                              we_a_i,
    input  logic [AddrWidth-1:0]              waddr_a_i,
    input  logic                              we_b_i,
    input  logic [AddrWidth-1:0]              waddr_b_i,
    input  logic                              flush_i,
    output logic [AddrWidth:0]                pending_cnt_o,
    output logic                              err_o
);

    logic [NumWords-1:0] pending_q;
    logic [NumWords-1:0] pending_d;
    logic [NumWords-1:0] clr_vec;
    logic [AddrWidth:0]  cnt_d;
    logic                issue_fire;
    fp_rf_err_e          err_d;
    fp_rf_err_e          err_q;

    // One-hot set of registers released by a writeback this cycle.
    // NOTE: every variable written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        clr_vec = '0;
        if (we_a_i) clr_vec[waddr_a_i] = 1'b1;
        if (we_b_i) clr_vec[waddr_b_i] = 1'b1;
    end

`ifdef IBEX_FP_RF_BYPASS_EN
    // A register being written back this cycle is already free.
    assign issue_ready_o = !pending_q[issue_addr_i] || clr_vec[issue_addr_i];
`else
    assign issue_ready_o = !pending_q[issue_addr_i];
`endif

    assign issue_fire = issue_valid_i && issue_ready_o;

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_busy
        logic [AddrWidth-1:0] addr;
        assign addr = raddr_i[p*AddrWidth +: AddrWidth];
`ifdef IBEX_FP_RF_BYPASS_EN
        assign rbusy_o[p] = pending_q[addr] && !clr_vec[addr];
`else
        assign rbusy_o[p] = pending_q[addr];
`endif
    end

    // Writebacks release, a new reservation then re-marks (issue wins over a
    // coincident write to the same register), and a flush overrides both.
    always_comb begin
        pending_d = pending_q & ~clr_vec;
        if (issue_fire) pending_d[issue_addr_i] = 1'b1;
        if (flush_i)    pending_d = '0;
    end

    always_comb begin
        err_d = ErrNone;
        if ((we_a_i && !pending_q[waddr_a_i]) || (we_b_i && !pending_q[waddr_b_i])) begin
            err_d = ErrNotPending;
        end
        if (we_a_i && we_b_i && (waddr_a_i == waddr_b_i)) begin
            err_d = ErrDualWrite;
        end
    end

    // Count of the next pending vector so the registered count tracks it.
    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < NumWords; i++) begin
            cnt_d = cnt_d + {{AddrWidth{1'b0}}, pending_d[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q     <= '0;
            pending_cnt_o <= '0;
            err_q         <= ErrNone;
        end else begin
            pending_q     <= pending_d;
            pending_cnt_o <= cnt_d;
            err_q         <= err_d;
        end
    end

    assign err_o = (err_q != ErrNone);

endmodule

// File: rtl/ibex_fp_regfile_sb.sv
// ibex_fp_regfile_sb
// Flop-based FP register file with an integrated scoreboard. Reads are
// combinational; two write ports (A: FPU, B: LSU load) land on the next edge,
// with port A taking priority when both target the same register.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   raddr_i / rdata_o    flattened read addresses / read data
//   rbusy_o              per read port: addressed register has a pending write
//   issue_valid_i/addr_i destination reservation request
//   issue_ready_o        reservation accepted this cycle
//   we_a_i/waddr_a_i/wdata_a_i  FPU writeback
//   we_b_i/waddr_b_i/wdata_b_i  LSU load writeback
//   flush_i              drop all reservations
//   pending_cnt_o        number of pending registers
//   err_o                one-cycle protocol-error pulse
//
// Build option: IBEX_FP_RF_BYPASS_EN forwards write data combinationally to
// matching read ports (port A priority) and lets the clearing write show on
// rbusy_o / issue_ready_o in the same cycle.
module ibex_fp_regfile_sb
    import ibex_fp_pkg::*;
#(
    parameter int unsigned          DataWidth    = 32,
    parameter int unsigned          NumWords     = FpRfNumWords,
    parameter int unsigned          NumReadPorts = 3,
    parameter logic [DataWidth-1:0] WordZeroVal  = '0,
    localparam int unsigned         AddrWidth    = $clog2(NumWords)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReadPorts*AddrWidth-1:0] raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    output logic [NumReadPorts-1:0]           rbusy_o,
    input  logic                              issue_valid_i,
    input  logic [AddrWidth-1:0]              issue_addr_i,
    output logic                              issue_ready_o,
    input  logic                              we_a_i,
    input  logic [AddrWidth-1:0]              waddr_a_i,
    input  logic [DataWidth-1:0]              wdata_a_i,
    input  logic                              we_b_i,
    input  logic [AddrWidth-1:0]              waddr_b_i,
    input  logic [DataWidth-1:0]              wdata_b_i,
    input  logic                              flush_i,
    output logic [AddrWidth:0]                pending_cnt_o,
    output logic                              err_o
);

    logic [DataWidth-1:0] mem_q [NumWords];

    // NOTE: the array is reset explicitly because every register must read
    // WordZeroVal after reset; this forces flops rather than a RAM macro.
    // Port B is written first so a same-address port A write overrides it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumWords; i++) begin
                mem_q[i] <= WordZeroVal;
            end
        end else begin
            if (we_b_i) mem_q[waddr_b_i] <= wdata_b_i;
            if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
        end
    end

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_read
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] rd;
        assign addr = raddr_i[p*AddrWidth +: AddrWidth];
`ifdef IBEX_FP_RF_BYPASS_EN
        always_comb begin
            rd = mem_q[addr];
            if (we_b_i && (waddr_b_i == addr)) rd = wdata_b_i;
            if (we_a_i && (waddr_a_i == addr)) rd = wdata_a_i;
        end
`else
        assign rd = mem_q[addr];
`endif
        assign rdata_o[p*DataWidth +: DataWidth] = rd;
    end

    ibex_fp_scoreboard #(
        .NumWords     (NumWords),
        .NumReadPorts (NumReadPorts),
        .AddrWidth    (AddrWidth)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .raddr_i       (raddr_i),
        .rbusy_o       (rbusy_o),
        .issue_valid_i (issue_valid_i),
        .issue_addr_i  (issue_addr_i),
        .issue_ready_o (issue_ready_o),
        .we_a_i        (we_a_i),
        .waddr_a_i     (waddr_a_i),
        .we_b_i        (we_b_i),
        .waddr_b_i     (waddr_b_i),
        .flush_i       (flush_i),
        .pending_cnt_o (pending_cnt_o),
        .err_o         (err_o)
    );

endmodule

// File: tb/tb_ibex_fp_regfile_sb.sv
// tb_ibex_fp_regfile_sb
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a behavioural model of the register file and scoreboard.
module tb_ibex_fp_regfile_sb;

    localparam int DW = 32;
    localparam int NW = 32;
    localparam int NR = 3;
    localparam int AW = 5;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NR*AW-1:0]  raddr_i;
    logic [NR*DW-1:0]  rdata_o;
    logic [NR-1:0]     rbusy_o;
    logic              issue_valid_i;
    logic [AW-1:0]     issue_addr_i;
    logic              issue_ready_o;
    logic              we_a_i;
    logic [AW-1:0]     waddr_a_i;
    logic [DW-1:0]     wdata_a_i;
    logic              we_b_i;
    logic [AW-1:0]     waddr_b_i;
    logic [DW-1:0]     wdata_b_i;
    logic              flush_i;
    logic [AW:0]       pending_cnt_o;
    logic              err_o;

    logic [AW-1:0]     ra [NR];
    assign raddr_i = {ra[2], ra[1], ra[0]};

    always #5 clk_i = ~clk_i;

    ibex_fp_regfile_sb dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .raddr_i       (raddr_i),
        .rdata_o       (rdata_o),
        .rbusy_o       (rbusy_o),
        .issue_valid_i (issue_valid_i),
        .issue_addr_i  (issue_addr_i),
        .issue_ready_o (issue_ready_o),
        .we_a_i        (we_a_i),
        .waddr_a_i     (waddr_a_i),
        .wdata_a_i     (wdata_a_i),
        .we_b_i        (we_b_i),
        .waddr_b_i     (waddr_b_i),
        .wdata_b_i     (wdata_b_i),
        .flush_i       (flush_i),
        .pending_cnt_o (pending_cnt_o),
        .err_o         (err_o)
    );

    // Reference model: register contents, reservation flags, error pulse.
    logic [DW-1:0] m_mem  [NW];
    bit            m_pend [NW];
    bit            m_err;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NW; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic bit wr_hit(input logic [AW-1:0] a);
        return (we_a_i && waddr_a_i == a) || (we_b_i && waddr_b_i == a);
    endfunction

    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
`ifdef IBEX_FP_RF_BYPASS_EN
        if (we_a_i && waddr_a_i == a) return wdata_a_i;
        if (we_b_i && waddr_b_i == a) return wdata_b_i;
`endif
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
`ifdef IBEX_FP_RF_BYPASS_EN
        return m_pend[a] && !wr_hit(a);
`else
        return m_pend[a];
`endif
    endfunction

    function automatic bit exp_ready();
`ifdef IBEX_FP_RF_BYPASS_EN
        return !m_pend[issue_addr_i] || wr_hit(issue_addr_i);
`else
        return !m_pend[issue_addr_i];
`endif
    endfunction

    task automatic idle();
        issue_valid_i = 1'b0;
        issue_addr_i  = '0;
        we_a_i        = 1'b0;
        waddr_a_i     = '0;
        wdata_a_i     = '0;
        we_b_i        = 1'b0;
        waddr_b_i     = '0;
        wdata_b_i     = '0;
        flush_i       = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied: checks the
    // combinational outputs, advances the model, clocks once, checks the
    // registered outputs and returns at the next falling edge.
    task automatic tick();
        bit ready;
        #1;
        for (int p = 0; p < NR; p++) begin
            check($sformatf("rdata[%0d]", p), rdata_o[p*DW +: DW], exp_rdata(ra[p]));
            check($sformatf("rbusy[%0d]", p), {31'b0, rbusy_o[p]}, {31'b0, exp_busy(ra[p])});
        end
        ready = exp_ready();
        check("issue_ready", {31'b0, issue_ready_o}, {31'b0, ready});

        m_err = (we_a_i && we_b_i && waddr_a_i == waddr_b_i)
             || (we_a_i && !m_pend[waddr_a_i])
             || (we_b_i && !m_pend[waddr_b_i]);
        if (we_b_i) m_mem[waddr_b_i] = wdata_b_i;
        if (we_a_i) m_mem[waddr_a_i] = wdata_a_i;
        if (we_a_i) m_pend[waddr_a_i] = 1'b0;
        if (we_b_i) m_pend[waddr_b_i] = 1'b0;
        if (issue_valid_i && ready) m_pend[issue_addr_i] = 1'b1;
        if (flush_i) for (int i = 0; i < NW; i++) m_pend[i] = 1'b0;

        @(posedge clk_i);
        #1;
        check("err", {31'b0, err_o}, {31'b0, m_err});
        check("pending_cnt", {26'b0, pending_cnt_o}, model_count());
        @(negedge clk_i);
    endtask

    initial begin
        // ---- reset and read every register ----
        idle();
        for (int p = 0; p < NR; p++) ra[p] = '0;
        rst_ni = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int a = 0; a < NW; a++) begin
            ra[0] = AW'(a);
            ra[1] = AW'(a);
            ra[2] = AW'(NW - 1 - a);
            #1;
            check("reset_rdata", rdata_o[0 +: DW], '0);
            check("reset_rdata2", rdata_o[2*DW +: DW], '0);
            check("reset_rbusy", {29'b0, rbusy_o}, '0);
        end
        check("reset_ready", {31'b0, issue_ready_o}, 32'd1);
        check("reset_cnt", {26'b0, pending_cnt_o}, '0);
        check("reset_err", {31'b0, err_o}, '0);
        @(negedge clk_i);

        // ---- reserve f5, write it back two cycles later ----
        ra[0] = 5'd5; ra[1] = 5'd0; ra[2] = 5'd0;
        issue_valid_i = 1'b1; issue_addr_i = 5'd5;
        tick();
        idle();
        #1;
        check("f5_busy", {31'b0, rbusy_o[0]}, 32'd1);
        check("f5_cnt1", {26'b0, pending_cnt_o}, 32'd1);
        tick();
        we_a_i = 1'b1; waddr_a_i = 5'd5; wdata_a_i = 32'h3F80_0000;
        tick();
        idle();
        #1;
        check("f5_data", rdata_o[0 +: DW], 32'h3F80_0000);
        check("f5_idle", {31'b0, rbusy_o[0]}, '0);
        check("f5_cnt0", {26'b0, pending_cnt_o}, '0);
        check("f5_noerr", {31'b0, err_o}, '0);
        tick();

        // ---- WAW stall on f7 ----
        ra[0] = 5'd7;
        issue_valid_i = 1'b1; issue_addr_i = 5'd7;
        tick();
        #1;
        check("f7_stall", {31'b0, issue_ready_o}, '0);
        tick();
        issue_valid_i = 1'b0;
        we_a_i = 1'b1; waddr_a_i = 5'd7; wdata_a_i = 32'h4000_0000;
        tick();
        idle();
        #1;
        check("f7_ready", {31'b0, issue_ready_o}, 32'd1);
        tick();

        // ---- dual write to pending f3 ----
        ra[0] = 5'd3;
        issue_valid_i = 1'b1; issue_addr_i = 5'd3;
        tick();
        idle();
        we_a_i = 1'b1; waddr_a_i = 5'd3; wdata_a_i = 32'h1111_1111;
        we_b_i = 1'b1; waddr_b_i = 5'd3; wdata_b_i = 32'h2222_2222;
        tick();
        idle();
        #1;
        check("dual_err", {31'b0, err_o}, 32'd1);
        check("dual_data", rdata_o[0 +: DW], 32'h1111_1111);
        tick();
        #1;
        check("dual_err_once", {31'b0, err_o}, '0);

        // ---- reserve f1, f2, f4 then flush ----
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd4;
        issue_valid_i = 1'b1;
        issue_addr_i = 5'd1; tick();
        issue_addr_i = 5'd2; tick();
        issue_addr_i = 5'd4; tick();
        idle();
        #1;
        check("flush_cnt3", {26'b0, pending_cnt_o}, 32'd3);
        check("flush_busy3", {29'b0, rbusy_o}, 32'd7);
        flush_i = 1'b1;
        tick();
        idle();
        #1;
        check("flush_cnt0", {26'b0, pending_cnt_o}, '0);
        check("flush_busy0", {29'b0, rbusy_o}, '0);
        check("flush_noerr", {31'b0, err_o}, '0);
        tick();

        // ---- write-to-read forwarding on f9 via port B ----
        ra[0] = 5'd0; ra[1] = 5'd9; ra[2] = 5'd0;
        issue_valid_i = 1'b1; issue_addr_i = 5'd9;
        tick();
        idle();
        we_b_i = 1'b1; waddr_b_i = 5'd9; wdata_b_i = 32'hDEAD_BEEF;
        #1;
`ifdef IBEX_FP_RF_BYPASS_EN
        check("byp_same", rdata_o[DW +: DW], 32'hDEAD_BEEF);
`else
        check("byp_same", rdata_o[DW +: DW], 32'h0000_0000);
`endif
        tick();
        idle();
        #1;
        check("byp_next", rdata_o[DW +: DW], 32'hDEAD_BEEF);
        tick();

        // ---- asynchronous reset mid-operation ----
        ra[0] = 5'd10; ra[1] = 5'd5; ra[2] = 5'd9;
        issue_valid_i = 1'b1; issue_addr_i = 5'd10;
        tick();
        issue_addr_i = 5'd11;
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_cnt", {26'b0, pending_cnt_o}, '0);
        check("arst_busy", {29'b0, rbusy_o}, '0);
        check("arst_f5", rdata_o[DW +: DW], '0);
        check("arst_f9", rdata_o[2*DW +: DW], '0);
        model_reset();
        idle();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // ---- random traffic over a small address window ----
        for (int n = 0; n < 600; n++) begin
            issue_valid_i = 1'($urandom_range(0, 1));
            issue_addr_i  = AW'($urandom_range(0, 7));
            we_a_i        = ($urandom_range(0, 9) < 4);
            waddr_a_i     = AW'($urandom_range(0, 7));
            wdata_a_i     = $urandom;
            we_b_i        = ($urandom_range(0, 9) < 3);
            waddr_b_i     = AW'($urandom_range(0, 7));
            wdata_b_i     = $urandom;
            flush_i       = ($urandom_range(0, 24) == 0);
            for (int p = 0; p < NR; p++) begin
                ra[p] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, NW - 1))
                                                    : AW'($urandom_range(0, 7));
            end
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
